// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline with ID-stage branch resolution.
// Covers operand forwarding selects, the load-use stall, taken-branch flushes,
// and a RUN/WAIT handshake with a slow data memory that includes a
// 15-cycle timeout. It also keeps a saturating count of stall cycles.
module pipeline_hazard_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic        id_branch_taken,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  edestReg,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [4:0]  mdestReg,
    input  logic        dmem_ready,
    output logic        wpcir,
    output logic        bubble_ex,
    output logic        flush_ifid,
    output logic        freeze,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        dmem_req,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;

    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       load_use;
    logic       mem_access;
    logic       req_c;
    logic       freeze_c;
    logic       timeout_c;

    assign mem_access = mm2reg | mwmem;

    // Operand select and load-use detection; a match in EXE wins over MEM.
    always_comb begin
        fwd_rs = 2'b00;
        fwd_rt = 2'b00;
        if (ewreg && !em2reg && (edestReg != 5'd0) && (edestReg == id_rs))
            fwd_rs = 2'b01;
        else if (mwreg && (mdestReg != 5'd0) && (mdestReg == id_rs))
            fwd_rs = mm2reg ? 2'b11 : 2'b10;
        if (ewreg && !em2reg && (edestReg != 5'd0) && (edestReg == id_rt))
            fwd_rt = 2'b01;
        else if (mwreg && (mdestReg != 5'd0) && (mdestReg == id_rt))
            fwd_rt = mm2reg ? 2'b11 : 2'b10;
        load_use = ewreg && em2reg && (edestReg != 5'd0) &&
                   ((id_rs_used && (edestReg == id_rs)) ||
                    (id_rt_used && (edestReg == id_rt)));
    end

    // Memory handshake decode: request, freeze, and timeout for this cycle.
    always_comb begin
        req_c     = 1'b0;
        freeze_c  = 1'b0;
        timeout_c = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_access) begin
                    req_c    = 1'b1;
                    freeze_c = !dmem_ready;
                end
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (!dmem_ready) begin
                    if (wait_cnt == 4'd15)
                        timeout_c = 1'b1;
                    else
                        freeze_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pipeline control outputs; a freeze masks stall/flush and reset forces a safe nop.
    always_comb begin
        wpcir      = 1'b1;
        bubble_ex  = 1'b0;
        flush_ifid = 1'b0;
        freeze     = 1'b0;
        dmem_req   = 1'b0;
        fwda       = 2'b00;
        fwdb       = 2'b00;
        if (reset) begin
            wpcir      = 1'b0;
            bubble_ex  = 1'b1;
            flush_ifid = 1'b1;
        end else begin
            freeze   = freeze_c;
            dmem_req = req_c;
            fwda     = fwd_rs;
            fwdb     = fwd_rt;
            if (freeze_c) begin
                wpcir = 1'b0;
            end else begin
                wpcir      = !load_use;
                bubble_ex  = load_use;
                flush_ifid = id_branch_taken && !load_use;
            end
        end
    end

    // RUN/WAIT sequencing with wait counter and sticky timeout flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            wait_cnt    <= 4'd0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (freeze_c) begin
                        state    <= ST_WAIT;
                        wait_cnt <= 4'd1;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ready || timeout_c) begin
                        state    <= ST_RUN;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                    if (timeout_c)
                        mem_timeout <= 1'b1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Saturating count of cycles in which the PC and IF/ID registers hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_cycles <= 16'd0;
        else if (!wpcir && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. The driver issues one input vector per
// cycle and computes the expected response with a cycle-level reference model.
// It pushes that response into a queue. The monitor pops the queue each cycle
// and compares the entry against the DUT outputs.
module tb_pipeline_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic [4:0]  id_rs, id_rt;
    logic        id_rs_used, id_rt_used, id_branch_taken;
    logic        ewreg, em2reg;
    logic [4:0]  edestReg;
    logic        mwreg, mm2reg, mwmem;
    logic [4:0]  mdestReg;
    logic        dmem_ready;
    logic        wpcir, bubble_ex, flush_ifid, freeze;
    logic [1:0]  fwda, fwdb;
    logic        dmem_req, mem_timeout;
    logic [15:0] stall_cycles;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic       br;
        logic       ewreg;
        logic       em2reg;
        logic [4:0] edest;
        logic       mwreg;
        logic       mm2reg;
        logic       mwmem;
        logic [4:0] mdest;
        logic       ready;
    } stim_t;

    typedef struct {
        int wpcir;
        int bubble;
        int flush;
        int freeze;
        int req;
        int fwda;
        int fwdb;
        int tmo;
        int stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state
    int   pend_age  = 0;
    int   tmo_flag  = 0;
    int   stall_cnt = 0;

    pipeline_hazard_ctrl dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_branch_taken(id_branch_taken),
        .ewreg(ewreg), .em2reg(em2reg), .edestReg(edestReg),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem), .mdestReg(mdestReg),
        .dmem_ready(dmem_ready),
        .wpcir(wpcir), .bubble_ex(bubble_ex), .flush_ifid(flush_ifid),
        .freeze(freeze), .fwda(fwda), .fwdb(fwdb),
        .dmem_req(dmem_req), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Operand source chosen by the forwarding rules for one source register.
    function automatic int refFwd(input stim_t s, input logic [4:0] src);
        if (s.ewreg == 1 && s.em2reg == 0 && s.edest != 0 && s.edest == src) return 1;
        if (s.mwreg == 1 && s.mdest != 0 && s.mdest == src) return (s.mm2reg == 1) ? 3 : 2;
        return 0;
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s = '{default: '0};
        s.ready = 1'b1;
        return s;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check("wpcir", int'(wpcir), e.wpcir);
        check("bubble_ex", int'(bubble_ex), e.bubble);
        check("flush_ifid", int'(flush_ifid), e.flush);
        check("freeze", int'(freeze), e.freeze);
        check("dmem_req", int'(dmem_req), e.req);
        check("fwda", int'(fwda), e.fwda);
        check("fwdb", int'(fwdb), e.fwdb);
        check("mem_timeout", int'(mem_timeout), e.tmo);
        check("stall_cycles", int'(stall_cycles), e.stall);
    endtask

    // Drive one cycle of inputs, predict the response, and advance the model.
    task automatic applyStimulus(input stim_t s, input logic r);
        exp_t e;
        bit   active, frz, lu, tmo_now;
        int   next_age;
        @(negedge clock);
        reset           = r;
        id_rs           = s.rs;
        id_rt           = s.rt;
        id_rs_used      = s.rs_used;
        id_rt_used      = s.rt_used;
        id_branch_taken = s.br;
        ewreg           = s.ewreg;
        em2reg          = s.em2reg;
        edestReg        = s.edest;
        mwreg           = s.mwreg;
        mm2reg          = s.mm2reg;
        mwmem           = s.mwmem;
        mdestReg        = s.mdest;
        dmem_ready      = s.ready;
        if (r) begin
            pend_age  = 0;
            tmo_flag  = 0;
            stall_cnt = 0;
            e = '{wpcir: 0, bubble: 1, flush: 1, freeze: 0, req: 0,
                  fwda: 0, fwdb: 0, tmo: 0, stall: 0};
            exp_q.push_back(e);
            return;
        end
        active   = (pend_age > 0) || s.mm2reg || s.mwmem;
        frz      = 0;
        tmo_now  = 0;
        next_age = 0;
        if (active && !s.ready) begin
            if (pend_age == 15) tmo_now = 1;
            else begin
                frz      = 1;
                next_age = pend_age + 1;
            end
        end
        lu = s.ewreg && s.em2reg && s.edest != 0 &&
             ((s.rs_used && s.edest == s.rs) || (s.rt_used && s.edest == s.rt));
        e.freeze = frz;
        e.req    = active;
        e.fwda   = refFwd(s, s.rs);
        e.fwdb   = refFwd(s, s.rt);
        e.wpcir  = (frz || lu) ? 0 : 1;
        e.bubble = (!frz && lu) ? 1 : 0;
        e.flush  = (!frz && !lu && s.br) ? 1 : 0;
        e.tmo    = tmo_flag;
        e.stall  = stall_cnt;
        exp_q.push_back(e);
        pend_age = next_age;
        if (tmo_now) tmo_flag = 1;
        if (e.wpcir == 0 && stall_cnt < 65535) stall_cnt++;
    endtask

    // Monitor: compare each pending expectation mid-cycle, away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;
        reset = 1'b1;
        id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0; id_branch_taken = 0;
        ewreg = 0; em2reg = 0; edestReg = '0;
        mwreg = 0; mm2reg = 0; mwmem = 0; mdestReg = '0; dmem_ready = 1;

        s = idleStim();
        repeat (2) applyStimulus(s, 1'b1);
        applyStimulus(s, 1'b0);

        // load-use on rs, then the load sits in MEM
        s = idleStim();
        s.ewreg = 1; s.em2reg = 1; s.edest = 5; s.rs = 5; s.rs_used = 1;
        applyStimulus(s, 1'b0);
        s = idleStim();
        s.mwreg = 1; s.mm2reg = 1; s.mdest = 5; s.rs = 5; s.rs_used = 1;
        applyStimulus(s, 1'b0);

        // forwarding priority on rt
        s = idleStim();
        s.ewreg = 1; s.edest = 3; s.mwreg = 1; s.mdest = 3; s.rt = 3; s.rt_used = 1;
        applyStimulus(s, 1'b0);
        s.edest = 0;
        applyStimulus(s, 1'b0);
        s.mdest = 0;
        applyStimulus(s, 1'b0);

        // store waits three cycles for memory
        s = idleStim();
        s.mwmem = 1; s.ready = 0;
        repeat (3) applyStimulus(s, 1'b0);
        s.ready = 1;
        applyStimulus(s, 1'b0);
        applyStimulus(idleStim(), 1'b0);

        // taken branch alone and alongside a load-use hazard
        s = idleStim();
        s.br = 1;
        applyStimulus(s, 1'b0);
        s.ewreg = 1; s.em2reg = 1; s.edest = 9; s.rt = 9; s.rt_used = 1;
        applyStimulus(s, 1'b0);

        // load never answered: timeout, then the flag persists
        s = idleStim();
        s.mm2reg = 1; s.ready = 0;
        repeat (16) applyStimulus(s, 1'b0);
        repeat (4) applyStimulus(idleStim(), 1'b0);

        // reset in the middle of a wait
        s = idleStim();
        s.mm2reg = 1; s.ready = 0;
        repeat (7) applyStimulus(s, 1'b0);
        applyStimulus(s, 1'b1);
        repeat (2) applyStimulus(idleStim(), 1'b0);

        // randomized traffic over a small register set to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.rs_used = 1'($urandom_range(0, 1));
            s.rt_used = 1'($urandom_range(0, 1));
            s.br      = ($urandom_range(0, 3) == 0);
            s.ewreg   = 1'($urandom_range(0, 1));
            s.em2reg  = 1'($urandom_range(0, 1));
            s.edest   = 5'($urandom_range(0, 3));
            s.mwreg   = 1'($urandom_range(0, 1));
            s.mm2reg  = ($urandom_range(0, 3) == 0);
            s.mwmem   = ($urandom_range(0, 5) == 0);
            s.mdest   = 5'($urandom_range(0, 3));
            s.ready   = ($urandom_range(0, 4) < 3);
            applyStimulus(s, ($urandom_range(0, 499) == 0));
        end

        // hold a load-use stall until the counter saturates
        applyStimulus(idleStim(), 1'b1);
        s = idleStim();
        s.ewreg = 1; s.em2reg = 1; s.edest = 7; s.rs = 7; s.rs_used = 1;
        repeat (65540) applyStimulus(s, 1'b0);
        repeat (2) applyStimulus(idleStim(), 1'b0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        @(negedge clock);
        #4;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
